// File: rtl/matrix_result_drain.sv
// Captures each new 2x2 product from the multiplier into a small result FIFO and
// streams it out one element per beat, MSB element first, over valid/ready.
module matrix_result_drain #(
  parameter int ELEM_W = 8,
  parameter int N_ELEM = 4,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 8,
  localparam int RES_W = ELEM_W * N_ELEM,
  localparam int IDX_W = $clog2(N_ELEM),
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LVL_W = $clog2(DEPTH) + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [RES_W-1:0]  matrix_result,
  input  logic [CNT_W-1:0]  matrix_count,
  output logic [ELEM_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [IDX_W-1:0]  out_index,
  output logic [LVL_W-1:0]  level,
  output logic              overflow,
  output logic [7:0]        drop_count
);

  logic [RES_W-1:0]  fifo_mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]  rd_ptr_reg, rd_ptr_next;
  logic [LVL_W-1:0]  level_reg, level_next, level_after_pop;
  logic [IDX_W-1:0]  index_reg, index_next;
  logic [CNT_W-1:0]  last_count_reg;
  logic              out_valid_reg, out_valid_next;
  logic              out_last_reg, out_last_next;
  logic [ELEM_W-1:0] out_data_reg, out_data_next;
  logic              overflow_reg;
  logic [7:0]        drop_count_reg;
  logic              capture, beat, pop, push, drop;
  logic [RES_W-1:0]  head_word;
  logic [ELEM_W-1:0] head_elems [N_ELEM];

  assign head_word = fifo_mem[rd_ptr_next];

  generate
    for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_elem
      assign head_elems[gi] = head_word[ELEM_W*(N_ELEM-gi)-1 -: ELEM_W];
    end
  endgenerate

  always_comb begin
    capture         = (matrix_count != last_count_reg);
    beat            = out_valid_reg && out_ready;
    pop             = beat && out_last_reg;
    level_after_pop = level_reg - LVL_W'(pop);
    // A full FIFO still has room when its head result leaves on this very edge.
    push            = capture && (level_after_pop < LVL_W'(DEPTH));
    drop            = capture && !push;
    level_next      = level_after_pop + LVL_W'(push);
    wr_ptr_next     = wr_ptr_reg + PTR_W'(push);
    rd_ptr_next     = rd_ptr_reg + PTR_W'(pop);
    if (pop)
      index_next = '0;
    else if (beat)
      index_next = index_reg + 1'b1;
    else
      index_next = index_reg;
    // Presentation only sees entries written on earlier edges, so no write bypass is needed.
    out_valid_next = (level_after_pop != '0);
    out_last_next  = out_valid_next && (index_next == IDX_W'(N_ELEM-1));
    out_data_next  = out_valid_next ? head_elems[index_next] : '0;
  end

  always_ff @(posedge clock) begin
    if (reset && push)
      fifo_mem[wr_ptr_reg] <= matrix_result;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      index_reg      <= '0;
      last_count_reg <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_data_reg   <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      index_reg      <= index_next;
      last_count_reg <= matrix_count;
      out_valid_reg  <= out_valid_next;
      out_last_reg   <= out_last_next;
      out_data_reg   <= out_data_next;
      overflow_reg   <= overflow_reg | drop;
      if (drop && drop_count_reg != 8'hFF)
        drop_count_reg <= drop_count_reg + 8'd1;
    end
  end

  assign out_data   = out_data_reg;
  assign out_valid  = out_valid_reg;
  assign out_last   = out_last_reg;
  assign out_index  = index_reg;
  assign level      = level_reg;
  assign overflow   = overflow_reg;
  assign drop_count = drop_count_reg;

endmodule
